// File: rtl/c2h_mm_mrkr_seq.sv
// c2h_mm_mrkr_seq: sequences C2H MM bypass descriptors into the QDMA bypass-in
// port through a 1-entry output register. On a CSR marker request it stalls
// upstream, drains the register, issues one marker descriptor and waits for the
// MM marker response, giving a per-queue "all prior descriptors retired" event.
// Optional build macro: C2H_MRKR_TIMEOUT_EN adds a response timeout of
// TIMEOUT_CYC cycles. Without it WAIT_RSP waits indefinitely and mrkr_timeout is 0.
module c2h_mm_mrkr_seq #(
  parameter int TIMEOUT_CYC = 65536,
  parameter int CNT_W       = 32
) (
  input  logic             axi_aclk,
  input  logic             axi_aresetn,
  input  logic             mrkr_start,
  input  logic [10:0]      mrkr_qid,
  input  logic [7:0]       mrkr_func,
  input  logic [2:0]       mrkr_port_id,
  input  logic             up_vld,
  output logic             up_rdy,
  input  logic [63:0]      up_radr,
  input  logic [63:0]      up_wadr,
  input  logic [27:0]      up_len,
  input  logic             up_sdi,
  input  logic [10:0]      up_qid,
  input  logic [7:0]       up_func,
  input  logic [15:0]      up_cidx,
  input  logic [2:0]       up_port_id,
  input  logic             up_error,
  output logic [63:0]      c2h_byp_in_mm_radr,
  output logic [63:0]      c2h_byp_in_mm_wadr,
  output logic [27:0]      c2h_byp_in_mm_len,
  output logic             c2h_byp_in_mm_mrkr_req,
  output logic             c2h_byp_in_mm_sdi,
  output logic [10:0]      c2h_byp_in_mm_qid,
  output logic             c2h_byp_in_mm_error,
  output logic [7:0]       c2h_byp_in_mm_func,
  output logic [15:0]      c2h_byp_in_mm_cidx,
  output logic [2:0]       c2h_byp_in_mm_port_id,
  output logic             c2h_byp_in_mm_no_dma,
  output logic             c2h_byp_in_mm_vld,
  input  logic             c2h_byp_in_mm_rdy,
  input  logic             c2h_mm_marker_rsp,
  output logic             mrkr_busy,
  output logic             mrkr_done,
  output logic             mrkr_timeout,
  output logic [CNT_W-1:0] desc_cnt
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;
  localparam logic [1:0] ST_WAIT  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic             run_q, run_d;      // low while in reset and one cycle after
  logic             vld_q, vld_d;
  logic [63:0]      radr_q, radr_d, wadr_q, wadr_d;
  logic [27:0]      len_q, len_d;
  logic             mrkr_q, mrkr_d, sdi_q, sdi_d, err_q, err_d, nodma_q, nodma_d;
  logic [10:0]      qid_q, qid_d, cap_qid_q, cap_qid_d;
  logic [7:0]       func_q, func_d, cap_func_q, cap_func_d;
  logic [15:0]      cidx_q, cidx_d;
  logic [2:0]       port_q, port_d, cap_port_q, cap_port_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d, tmo_q, tmo_d;
  logic             hs, accept;

`ifdef C2H_MRKR_TIMEOUT_EN
  localparam int TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TMR_W-1:0] tmr_q, tmr_d;
`endif

  assign hs     = vld_q & c2h_byp_in_mm_rdy;
  assign up_rdy = run_q & (state_q == ST_IDLE) & (~vld_q | c2h_byp_in_mm_rdy);
  assign accept = up_vld & up_rdy;

  // Next-state: output register load/drain, descriptor counter, marker FSM
  always_comb begin
    state_d    = state_q;
    run_d      = 1'b1;
    vld_d      = vld_q;
    radr_d     = radr_q;
    wadr_d     = wadr_q;
    len_d      = len_q;
    mrkr_d     = mrkr_q;
    sdi_d      = sdi_q;
    err_d      = err_q;
    nodma_d    = nodma_q;
    qid_d      = qid_q;
    func_d     = func_q;
    cidx_d     = cidx_q;
    port_d     = port_q;
    cap_qid_d  = cap_qid_q;
    cap_func_d = cap_func_q;
    cap_port_d = cap_port_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    tmo_d      = 1'b0;
`ifdef C2H_MRKR_TIMEOUT_EN
    tmr_d      = tmr_q;
`endif

    if (hs) begin
      vld_d = 1'b0;
      if (!mrkr_q) cnt_d = cnt_q + CNT_W'(1);
    end

    // A new data descriptor may replace one leaving in the same cycle
    if (accept) begin
      vld_d   = 1'b1;
      radr_d  = up_radr;
      wadr_d  = up_wadr;
      len_d   = up_len;
      mrkr_d  = 1'b0;
      sdi_d   = up_sdi;
      err_d   = up_error;
      nodma_d = 1'b0;
      qid_d   = up_qid;
      func_d  = up_func;
      cidx_d  = up_cidx;
      port_d  = up_port_id;
    end

    case (state_q)
      ST_IDLE: begin
        if (mrkr_start) begin
          cap_qid_d  = mrkr_qid;
          cap_func_d = mrkr_func;
          cap_port_d = mrkr_port_id;
          state_d    = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Register is free next cycle: load the marker directly into it
        if (!vld_q || hs) begin
          vld_d   = 1'b1;
          radr_d  = '0;
          wadr_d  = '0;
          len_d   = '0;
          mrkr_d  = 1'b1;
          sdi_d   = 1'b0;
          err_d   = 1'b0;
          nodma_d = 1'b1;
          qid_d   = cap_qid_q;
          func_d  = cap_func_q;
          cidx_d  = '0;
          port_d  = cap_port_q;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (hs) begin
          if (c2h_mm_marker_rsp) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT;
`ifdef C2H_MRKR_TIMEOUT_EN
            tmr_d   = '0;
`endif
          end
        end
      end
      default: begin
        if (c2h_mm_marker_rsp) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
`ifdef C2H_MRKR_TIMEOUT_EN
        else if (tmr_q == TMR_W'(TIMEOUT_CYC - 1)) begin
          tmo_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmr_d   = tmr_q + TMR_W'(1);
        end
`endif
      end
    endcase
  end

  // State and output register; async reset drops any pending descriptor
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q    <= ST_IDLE;
      run_q      <= 1'b0;
      vld_q      <= 1'b0;
      radr_q     <= '0;
      wadr_q     <= '0;
      len_q      <= '0;
      mrkr_q     <= 1'b0;
      sdi_q      <= 1'b0;
      err_q      <= 1'b0;
      nodma_q    <= 1'b0;
      qid_q      <= '0;
      func_q     <= '0;
      cidx_q     <= '0;
      port_q     <= '0;
      cap_qid_q  <= '0;
      cap_func_q <= '0;
      cap_port_q <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      vld_q      <= vld_d;
      radr_q     <= radr_d;
      wadr_q     <= wadr_d;
      len_q      <= len_d;
      mrkr_q     <= mrkr_d;
      sdi_q      <= sdi_d;
      err_q      <= err_d;
      nodma_q    <= nodma_d;
      qid_q      <= qid_d;
      func_q     <= func_d;
      cidx_q     <= cidx_d;
      port_q     <= port_d;
      cap_qid_q  <= cap_qid_d;
      cap_func_q <= cap_func_d;
      cap_port_q <= cap_port_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      tmo_q      <= tmo_d;
    end
  end

`ifdef C2H_MRKR_TIMEOUT_EN
  // Response-wait cycle counter
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) tmr_q <= '0;
    else              tmr_q <= tmr_d;
  end
`endif

  assign c2h_byp_in_mm_radr     = radr_q;
  assign c2h_byp_in_mm_wadr     = wadr_q;
  assign c2h_byp_in_mm_len      = len_q;
  assign c2h_byp_in_mm_mrkr_req = mrkr_q;
  assign c2h_byp_in_mm_sdi      = sdi_q;
  assign c2h_byp_in_mm_qid      = qid_q;
  assign c2h_byp_in_mm_error    = err_q;
  assign c2h_byp_in_mm_func     = func_q;
  assign c2h_byp_in_mm_cidx     = cidx_q;
  assign c2h_byp_in_mm_port_id  = port_q;
  assign c2h_byp_in_mm_no_dma   = nodma_q;
  assign c2h_byp_in_mm_vld      = vld_q;
  assign mrkr_busy              = (state_q != ST_IDLE);
  assign mrkr_done              = done_q;
  assign mrkr_timeout           = tmo_q;
  assign desc_cnt               = cnt_q;

endmodule

// File: tb/tb_c2h_mm_mrkr_seq.sv
// Self-checking bench for c2h_mm_mrkr_seq: table of per-cycle vectors plus
// hand-written sequences for same-cycle response, timeout and async reset.
module tb_c2h_mm_mrkr_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mrkr_start = 1'b0;
  logic [10:0] mrkr_qid = 11'h005;
  logic [7:0]  mrkr_func = 8'h02;
  logic [2:0]  mrkr_port_id = 3'h1;
  logic        up_vld = 1'b0;
  logic        up_rdy;
  logic [63:0] up_radr = '0, up_wadr = '0;
  logic [27:0] up_len = '0;
  logic        up_sdi = 1'b0, up_error = 1'b0;
  logic [10:0] up_qid = '0;
  logic [7:0]  up_func = '0;
  logic [15:0] up_cidx = '0;
  logic [2:0]  up_port_id = '0;
  logic [63:0] o_radr, o_wadr;
  logic [27:0] o_len;
  logic        o_mrkr, o_sdi, o_err, o_nodma, o_vld;
  logic [10:0] o_qid;
  logic [7:0]  o_func;
  logic [15:0] o_cidx;
  logic [2:0]  o_port;
  logic        byp_rdy = 1'b0;
  logic        rsp = 1'b0;
  logic        busy, done, tmo;
  logic [31:0] cnt;

  int checks = 0;
  int errs   = 0;

  always #5 clk = ~clk;

  c2h_mm_mrkr_seq #(.TIMEOUT_CYC(16), .CNT_W(32)) dut (
    .axi_aclk(clk), .axi_aresetn(rst_n),
    .mrkr_start(mrkr_start), .mrkr_qid(mrkr_qid), .mrkr_func(mrkr_func),
    .mrkr_port_id(mrkr_port_id),
    .up_vld(up_vld), .up_rdy(up_rdy), .up_radr(up_radr), .up_wadr(up_wadr),
    .up_len(up_len), .up_sdi(up_sdi), .up_qid(up_qid), .up_func(up_func),
    .up_cidx(up_cidx), .up_port_id(up_port_id), .up_error(up_error),
    .c2h_byp_in_mm_radr(o_radr), .c2h_byp_in_mm_wadr(o_wadr),
    .c2h_byp_in_mm_len(o_len), .c2h_byp_in_mm_mrkr_req(o_mrkr),
    .c2h_byp_in_mm_sdi(o_sdi), .c2h_byp_in_mm_qid(o_qid),
    .c2h_byp_in_mm_error(o_err), .c2h_byp_in_mm_func(o_func),
    .c2h_byp_in_mm_cidx(o_cidx), .c2h_byp_in_mm_port_id(o_port),
    .c2h_byp_in_mm_no_dma(o_nodma), .c2h_byp_in_mm_vld(o_vld),
    .c2h_byp_in_mm_rdy(byp_rdy), .c2h_mm_marker_rsp(rsp),
    .mrkr_busy(busy), .mrkr_done(done), .mrkr_timeout(tmo), .desc_cnt(cnt)
  );

  typedef struct {
    logic       uv;
    logic [7:0] tag;
    logic       br, ms, rs;
    logic       e_urdy, e_vld;
    logic [7:0] e_tag;
    logic       e_mrkr, e_busy, e_done;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic uv, logic [7:0] tag, logic br, logic ms, logic rs,
                              logic e_urdy, logic e_vld, logic [7:0] e_tag,
                              logic e_mrkr, logic e_busy, logic e_done, logic [31:0] e_cnt);
    vec_t v;
    v.uv = uv; v.tag = tag; v.br = br; v.ms = ms; v.rs = rs;
    v.e_urdy = e_urdy; v.e_vld = e_vld; v.e_tag = e_tag;
    v.e_mrkr = e_mrkr; v.e_busy = e_busy; v.e_done = e_done; v.e_cnt = e_cnt;
    return v;
  endfunction

  // Payload packing: radr,wadr,len,mrkr,sdi,qid,err,func,cidx,port,no_dma (198 bits)
  function automatic logic [199:0] exp_data(logic [7:0] t);
    logic [63:0] ra, wa;
    ra = 64'h1111_0000_0000_0000 + 64'(t);
    wa = 64'h2222_0000_0000_0000 + 64'(t) * 64'd16;
    return {2'b00, ra, wa, 28'(t) * 28'd3 + 28'd1, 1'b0, t[0], 11'(t) + 11'h100,
            t[1], t ^ 8'h5A, {t, t}, t[2:0], 1'b0};
  endfunction

  function automatic logic [199:0] exp_marker();
    return {2'b00, 64'h0, 64'h0, 28'h0, 1'b1, 1'b0, 11'h005, 1'b0, 8'h02, 16'h0, 3'h1, 1'b1};
  endfunction

  function automatic logic [199:0] act_payload();
    return {2'b00, o_radr, o_wadr, o_len, o_mrkr, o_sdi, o_qid, o_err, o_func, o_cidx,
            o_port, o_nodma};
  endfunction

  task automatic drive_up(logic v, logic [7:0] t);
    up_vld     = v;
    up_radr    = 64'h1111_0000_0000_0000 + 64'(t);
    up_wadr    = 64'h2222_0000_0000_0000 + 64'(t) * 64'd16;
    up_len     = 28'(t) * 28'd3 + 28'd1;
    up_sdi     = t[0];
    up_qid     = 11'(t) + 11'h100;
    up_error   = t[1];
    up_func    = t ^ 8'h5A;
    up_cidx    = {t, t};
    up_port_id = t[2:0];
  endtask

  task automatic chk(string nm, logic [199:0] act, logic [199:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int tmo_seen;

    // Passthrough, 8 back-to-back
    tbl.push_back(mk(1, 8'h01, 1, 0, 0, 1, 0, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h02, 1, 0, 0, 1, 1, 8'h01, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h03, 1, 0, 0, 1, 1, 8'h02, 0, 0, 0, 1));
    tbl.push_back(mk(1, 8'h04, 1, 0, 0, 1, 1, 8'h03, 0, 0, 0, 2));
    tbl.push_back(mk(1, 8'h05, 1, 0, 0, 1, 1, 8'h04, 0, 0, 0, 3));
    tbl.push_back(mk(1, 8'h06, 1, 0, 0, 1, 1, 8'h05, 0, 0, 0, 4));
    tbl.push_back(mk(1, 8'h07, 1, 0, 0, 1, 1, 8'h06, 0, 0, 0, 5));
    tbl.push_back(mk(1, 8'h08, 1, 0, 0, 1, 1, 8'h07, 0, 0, 0, 6));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 1, 1, 8'h08, 0, 0, 0, 7));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 1, 0, 8'h00, 0, 0, 0, 8));
    // Backpressure, rdy alternating
    tbl.push_back(mk(1, 8'h11, 0, 0, 0, 1, 0, 8'h00, 0, 0, 0, 8));
    tbl.push_back(mk(1, 8'h12, 1, 0, 0, 1, 1, 8'h11, 0, 0, 0, 8));
    tbl.push_back(mk(1, 8'h13, 0, 0, 0, 0, 1, 8'h12, 0, 0, 0, 9));
    tbl.push_back(mk(1, 8'h13, 1, 0, 0, 1, 1, 8'h12, 0, 0, 0, 9));
    tbl.push_back(mk(1, 8'h14, 0, 0, 0, 0, 1, 8'h13, 0, 0, 0, 10));
    tbl.push_back(mk(1, 8'h14, 1, 0, 0, 1, 1, 8'h13, 0, 0, 0, 10));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 8'h14, 0, 0, 0, 11));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 1, 1, 8'h14, 0, 0, 0, 11));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 8'h00, 0, 0, 0, 12));
    // Marker after 3 descriptors, start with the 3rd accept
    tbl.push_back(mk(1, 8'h21, 1, 0, 0, 1, 0, 8'h00, 0, 0, 0, 12));
    tbl.push_back(mk(1, 8'h22, 1, 0, 0, 1, 1, 8'h21, 0, 0, 0, 12));
    tbl.push_back(mk(1, 8'h23, 1, 1, 0, 1, 1, 8'h22, 0, 0, 0, 13));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1, 8'h23, 0, 1, 0, 14));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 8'h00, 1, 1, 0, 15));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1, 8'h00, 1, 1, 0, 15));
    for (int i = 0; i < 9; i++)  // waiting; start request in WAIT_RSP is ignored
      tbl.push_back(mk(0, 8'h00, 1, (i == 2), 0, 0, 0, 8'h00, 0, 1, 0, 15));
    tbl.push_back(mk(0, 8'h00, 1, 0, 1, 0, 0, 8'h00, 0, 1, 0, 15));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 1, 0, 8'h00, 0, 0, 1, 15));
    tbl.push_back(mk(0, 8'h00, 1, 0, 1, 1, 0, 8'h00, 0, 0, 0, 15));  // rsp in IDLE
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 1, 0, 8'h00, 0, 0, 0, 15));
    tbl.push_back(mk(1, 8'h24, 1, 0, 0, 1, 0, 8'h00, 0, 0, 0, 15));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 1, 1, 8'h24, 0, 0, 0, 15));
    tbl.push_back(mk(0, 8'h00, 1, 0, 0, 1, 0, 8'h00, 0, 0, 0, 16));

    // Reset state
    #2;
    chk("rst_urdy", 200'(up_rdy), 200'(0));
    chk("rst_vld", 200'(o_vld), 200'(0));
    chk("rst_busy", 200'(busy), 200'(0));
    chk("rst_cnt", 200'(cnt), 200'(0));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    tick();

    for (int i = 0; i < tbl.size(); i++) begin
      drive_up(tbl[i].uv, tbl[i].tag);
      byp_rdy    = tbl[i].br;
      mrkr_start = tbl[i].ms;
      rsp        = tbl[i].rs;
      #1;
      chk($sformatf("r%0d_urdy", i), 200'(up_rdy), 200'(tbl[i].e_urdy));
      chk($sformatf("r%0d_vld", i), 200'(o_vld), 200'(tbl[i].e_vld));
      if (tbl[i].e_vld)
        chk($sformatf("r%0d_payload", i), act_payload(),
            tbl[i].e_mrkr ? exp_marker() : exp_data(tbl[i].e_tag));
      chk($sformatf("r%0d_busy", i), 200'(busy), 200'(tbl[i].e_busy));
      chk($sformatf("r%0d_done", i), 200'(done), 200'(tbl[i].e_done));
      chk($sformatf("r%0d_tmo", i), 200'(tmo), 200'(0));
      chk($sformatf("r%0d_cnt", i), 200'(cnt), 200'(tbl[i].e_cnt));
      @(posedge clk);
      #1;
    end
    drive_up(0, 8'h00);
    mrkr_start = 0;
    rsp = 0;

    // Response in the same cycle as the marker handshake
    byp_rdy = 1; mrkr_start = 1; tick();
    mrkr_start = 0; tick();
    chk("sc_vld", 200'(o_vld), 200'(1));
    chk("sc_marker", act_payload(), exp_marker());
    rsp = 1; tick();
    rsp = 0;
    chk("sc_done", 200'(done), 200'(1));
    chk("sc_busy", 200'(busy), 200'(0));
    chk("sc_vld_after", 200'(o_vld), 200'(0));
    chk("sc_cnt", 200'(cnt), 200'(16));
    tick();
    chk("sc_done_pulse", 200'(done), 200'(0));

    // No response: timeout (macro on) or indefinite wait (macro off)
    byp_rdy = 0; mrkr_start = 1; tick();
    mrkr_start = 0; tick();
    byp_rdy = 1; tick();
    chk("to_busy_wait", 200'(busy), 200'(1));
`ifdef C2H_MRKR_TIMEOUT_EN
    n = 0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (tmo) begin
        n = k;
        break;
      end
    end
    chk("to_cycles", 200'(n), 200'(16));
    chk("to_busy", 200'(busy), 200'(0));
    chk("to_urdy", 200'(up_rdy), 200'(1));
    chk("to_nodone", 200'(done), 200'(0));
    tick();
    chk("to_pulse", 200'(tmo), 200'(0));
`else
    tmo_seen = 0;
    repeat (1000) begin
      tick();
      if (tmo) tmo_seen++;
    end
    chk("nt_busy", 200'(busy), 200'(1));
    chk("nt_tmo", 200'(tmo_seen), 200'(0));
    rsp = 1; tick();
    rsp = 0;
    chk("nt_done", 200'(done), 200'(1));
    chk("nt_idle", 200'(busy), 200'(0));
`endif

    // Async reset while the marker is pending in ISSUE
    byp_rdy = 0; mrkr_start = 1; tick();
    mrkr_start = 0; tick();
    chk("ar_vld_pre", 200'(o_vld), 200'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("ar_vld", 200'(o_vld), 200'(0));
    chk("ar_mrkr", 200'(o_mrkr), 200'(0));
    chk("ar_busy", 200'(busy), 200'(0));
    chk("ar_urdy", 200'(up_rdy), 200'(0));
    chk("ar_cnt", 200'(cnt), 200'(0));
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    byp_rdy = 1;
    drive_up(1, 8'h31);
    #1;
    chk("ar_urdy_post", 200'(up_rdy), 200'(1));
    tick();
    drive_up(0, 8'h00);
    chk("ar_out_vld", 200'(o_vld), 200'(1));
    chk("ar_out_payload", act_payload(), exp_data(8'h31));
    tick();
    chk("ar_out_cnt", 200'(cnt), 200'(1));
    chk("ar_out_busy", 200'(busy), 200'(0));
    chk("ar_out_done", 200'(done), 200'(0));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
